dpram_gen: RTL and testbench

Parametrised true dual-port block RAM, successor to the fixed 16-bit dual-port memory used as unified instruction/data store. Adds configurable width/depth, a selectable same-port read-during-write mode, an optional output pipeline register, read-valid strobes, cross-port write-collision detection, and a post-reset clear engine that zeroes the array before accepting traffic. Sits between the CPU datapath (port A) and the display/IO fetch logic (port B).

---
 rtl/dpram_gen.sv | 184 ++++++++++++++++++
 tb/tb_dpram_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_gen.sv
// Parametrised true dual-port RAM with post-reset clear engine, selectable
// read-during-write behaviour, optional output register and collision flag.
module dpram_gen #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_A,
    input  logic              we_A,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] out_A,
    output logic              valid_A,
    input  logic              en_B,
    input  logic              we_B,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [DATA_W-1:0] data_B,
    output logic [DATA_W-1:0] out_B,
    output logic              valid_B,
    output logic              ready,
    output logic              collision
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE_WAIT, ST_READY} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE_WAIT;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
            end
            ST_IDLE_WAIT: state_d = ST_READY;
            default: ;
        endcase
        ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Port signals gathered into arrays so both ports share one generate body.
    logic              p_en   [2];
    logic              p_we   [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_din  [2];
    logic [DATA_W-1:0] p_out  [2];
    logic              p_valid[2];
    logic              p_acc  [2];
    logic              p_wr   [2];

    assign p_en[0]   = en_A;
    assign p_we[0]   = we_A;
    assign p_addr[0] = addr_A;
    assign p_din[0]  = data_A;
    assign p_en[1]   = en_B;
    assign p_we[1]   = we_B;
    assign p_addr[1] = addr_B;
    assign p_din[1]  = data_B;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clearing;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;

    // The clear engine borrows port A's write path; user traffic is blocked then.
    always_comb begin
        clearing = (state_q == ST_CLEAR) && !rst;
        wa_en    = clearing || p_wr[0];
        wa_addr  = clearing ? clr_cnt_q : addr_A;
        wa_data  = clearing ? '0 : data_A;
    end

    // B is written first so that A's write wins on a same-address collision.
    always_ff @(posedge clk) begin
        if (p_wr[1]) mem[addr_B] <= data_B;
        if (wa_en)   mem[wa_addr] <= wa_data;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rd_q;
            logic              seen_q, seen_d;
            logic              valid1_q, valid1_d;
            logic [DATA_W-1:0] out1;

            assign p_acc[gi] = ready_q && p_en[gi];
            assign p_wr[gi]  = p_acc[gi] && p_we[gi];

            always_ff @(posedge clk) begin
                if (p_acc[gi])
                    rd_q <= (p_wr[gi] && RDW_MODE == 0) ? p_din[gi] : mem[p_addr[gi]];
            end

            always_comb begin
                seen_d   = seen_q || p_acc[gi];
                valid1_d = p_acc[gi];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seen_q   <= 1'b0;
                    valid1_q <= 1'b0;
                end else begin
                    seen_q   <= seen_d;
                    valid1_q <= valid1_d;
                end
            end

            // The RAM read register has no reset; mask it until a fresh access lands.
            assign out1 = seen_q ? rd_q : '0;

            if (OUT_REG != 0) begin : g_pipe
                logic [DATA_W-1:0] out2_q;
                logic              valid2_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        out2_q   <= '0;
                        valid2_q <= 1'b0;
                    end else begin
                        out2_q   <= out1;
                        valid2_q <= valid1_q;
                    end
                end
                assign p_out[gi]   = out2_q;
                assign p_valid[gi] = valid2_q;
            end else begin : g_direct
                assign p_out[gi]   = out1;
                assign p_valid[gi] = valid1_q;
            end
        end
    endgenerate

    logic coll1_q, coll1_d;
    logic coll_out;

    assign coll1_d = p_wr[0] && p_wr[1] && (addr_A == addr_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll1_q <= 1'b0;
        else     coll1_q <= coll1_d;
    end

    generate
        if (OUT_REG != 0) begin : g_coll_pipe
            logic coll2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) coll2_q <= 1'b0;
                else     coll2_q <= coll1_q;
            end
            assign coll_out = coll2_q;
        end else begin : g_coll_direct
            assign coll_out = coll1_q;
        end
    endgenerate

    assign out_A     = p_out[0];
    assign valid_A   = p_valid[0];
    assign out_B     = p_out[1];
    assign valid_B   = p_valid[1];
    assign ready     = ready_q;
    assign collision = coll_out;
endmodule

// File: tb/tb_dpram_gen.sv
// Bench for dpram_gen: two instances (write-first/no out reg, read-first/out reg)
// share one stimulus stream and are checked against a behavioural memory model.
module tb_dpram_gen;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_A = 0, we_A = 0, en_B = 0, we_B = 0;
    logic [AW-1:0] addr_A = '0, addr_B = '0;
    logic [DW-1:0] data_A = '0, data_B = '0;

    logic [DW-1:0] oa0, ob0, oa1, ob1;
    logic          va0, vb0, va1, vb1, rdy0, rdy1, c0, c1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_gen #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst),
        .en_A(en_A), .we_A(we_A), .addr_A(addr_A), .data_A(data_A), .out_A(oa0), .valid_A(va0),
        .en_B(en_B), .we_B(we_B), .addr_B(addr_B), .data_B(data_B), .out_B(ob0), .valid_B(vb0),
        .ready(rdy0), .collision(c0));

    dpram_gen #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst),
        .en_A(en_A), .we_A(we_A), .addr_A(addr_A), .data_A(data_A), .out_A(oa1), .valid_A(va1),
        .en_B(en_B), .we_B(we_B), .addr_B(addr_B), .data_B(data_B), .out_B(ob1), .valid_B(vb1),
        .ready(rdy1), .collision(c1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents plus what each instance must show.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready = 0;
    int            m_cnt = 0;
    logic [DW-1:0] old_a, old_b;
    logic [DW-1:0] e_oa0 = 0, e_ob0 = 0, e_oa1 = 0, e_ob1 = 0, n_oa1 = 0, n_ob1 = 0;
    bit            e_va0 = 0, e_vb0 = 0, e_c0 = 0, e_va1 = 0, e_vb1 = 0, e_c1 = 0;
    bit            n_va1 = 0, n_vb1 = 0, n_c1 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 0; m_cnt = 0;
            e_oa0 = 0; e_ob0 = 0; e_oa1 = 0; e_ob1 = 0; n_oa1 = 0; n_ob1 = 0;
            e_va0 = 0; e_vb0 = 0; e_c0 = 0; e_va1 = 0; e_vb1 = 0; e_c1 = 0;
            n_va1 = 0; n_vb1 = 0; n_c1 = 0;
        end else begin
            // The two-stage instance shows what was computed one edge earlier.
            e_oa1 = n_oa1; e_ob1 = n_ob1; e_va1 = n_va1; e_vb1 = n_vb1; e_c1 = n_c1;
            e_va0 = 0; e_vb0 = 0; e_c0 = 0;
            if (!m_ready) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_ready = 1;
                    foreach (m_mem[i]) m_mem[i] = '0;
                end
            end else begin
                old_a = m_mem[addr_A];
                old_b = m_mem[addr_B];
                if (en_A) begin e_va0 = 1; e_oa0 = we_A ? data_A : old_a; n_oa1 = old_a; end
                if (en_B) begin e_vb0 = 1; e_ob0 = we_B ? data_B : old_b; n_ob1 = old_b; end
                e_c0 = en_A && we_A && en_B && we_B && (addr_A == addr_B);
                if (en_B && we_B) m_mem[addr_B] = data_B;
                if (en_A && we_A) m_mem[addr_A] = data_A;
            end
            n_va1 = e_va0; n_vb1 = e_vb0; n_c1 = e_c0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ready0", rdy0, m_ready);   check("ready1", rdy1, m_ready);
            check("out_A0", oa0, e_oa0);      check("valid_A0", va0, e_va0);
            check("out_B0", ob0, e_ob0);      check("valid_B0", vb0, e_vb0);
            check("coll0", c0, e_c0);
            check("out_A1", oa1, e_oa1);      check("valid_A1", va1, e_va1);
            check("out_B1", ob1, e_ob1);      check("valid_B1", vb1, e_vb1);
            check("coll1", c1, e_c1);
        end
    end

    task automatic cyc(input bit ea, input bit wa, input int aa, input int da,
                       input bit eb, input bit wb, input int ab, input int db);
        en_A = ea; we_A = wa; addr_A = AW'(aa); data_A = DW'(da);
        en_B = eb; we_B = wb; addr_B = AW'(ab); data_B = DW'(db);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        cyc(1, 0, 9, 0, 1, 0, 9, 0);
        n = 1;
        check({name, "_valid_during_clear"}, va0, 0);
        while (!rdy0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, n, DEPTH);
        en_A = 0; en_B = 0;
    endtask

    task automatic fill_beef();
        for (int i = 0; i < DEPTH / 2; i++) cyc(1, 1, i, 'hBEEF, 1, 1, i + DEPTH / 2, 'hBEEF);
        cyc(1, 0, 5, 0, 0, 0, 0, 0);
        check("beef_rd", oa0, 'hBEEF);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < DEPTH / 2; i++) begin
            cyc(1, 0, i, 0, 1, 0, i + DEPTH / 2, 0);
            check("clr_rdA", oa0, 0);
            check("clr_rdB", ob0, 0);
        end
    endtask

    task automatic pulse_rst();
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_A0", oa0, 0);   check("rst_valid_A0", va0, 0);
        check("rst_ready0", rdy0, 0);  check("rst_coll0", c0, 0);
        check("rst_out_B1", ob1, 0);   check("rst_ready1", rdy1, 0);
        rst = 0;
        wait_ready("ready_first");

        fill_beef();
        pulse_rst();
        wait_ready("ready_after_rst");
        read_all_zero();

        fill_beef();
        pulse_rst();
        repeat (500) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_ready("ready_mid_clear");
        read_all_zero();

        cyc(1, 1, 5, 'h1234, 0, 0, 0, 0);
        idle();
        cyc(1, 0, 5, 0, 0, 0, 0, 0);
        check("lat1_out", oa0, 'h1234);   check("lat1_valid", va0, 1);
        check("lat2_hold", oa1, 0);       check("lat2_novalid", va1, 0);
        idle();
        check("lat2_out", oa1, 'h1234);   check("lat2_valid", va1, 1);
        check("lat1_idle_hold", oa0, 'h1234); check("lat1_idle_valid", va0, 0);

        cyc(1, 1, 7, 'h00AA, 0, 0, 0, 0);
        cyc(1, 1, 7, 'h0055, 0, 0, 0, 0);
        check("rdw_wf", oa0, 'h0055);
        idle();
        check("rdw_rf", oa1, 'h00AA);
        cyc(1, 0, 7, 0, 0, 0, 0, 0);
        check("rdw_after", oa0, 'h0055);

        cyc(1, 1, 3, 'h1111, 1, 1, 3, 'h2222);
        check("coll_pulse0", c0, 1);  check("coll_outB0", ob0, 'h2222);
        check("coll_early1", c1, 0);
        idle();
        check("coll_end0", c0, 0);    check("coll_pulse1", c1, 1);
        check("coll_outB1", ob1, 0);
        cyc(1, 1, 3, 'h3333, 1, 0, 3, 0);
        check("wr_rd_old", ob0, 'h1111); check("wr_rd_nocoll", c0, 0);
        check("coll_end1", c1, 0);
        cyc(0, 0, 0, 0, 1, 0, 3, 0);
        check("wr_visible", ob0, 'h3333);

        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                int'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                int'($urandom_range(0, 65535)));
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
